fft_frame_arbiter: RTL and testbench

Shares one 64-point in-place radix-2 DIF FFT core between two frame sources. It arbitrates frame requests round-robin and pulses the core start. It streams the granted source's samples into the core, waits for the core's output phase, then tags the drained output with the owning requester. Only one frame is in flight at a time; a compute watchdog recovers from a hung core.

---
 rtl/fft_frame_arbiter_pkg.sv | 32 +++
 rtl/fft_frame_arbiter_if.sv | 41 ++++
 rtl/fft_frame_arbiter_rr_arb2.sv | 37 +++
 rtl/fft_frame_arbiter.sv | 157 +++++++++++++++
 tb/tb_fft_frame_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fft_frame_arbiter_pkg.sv
//------------------------------------------------------------------------------
// fft_pkg : shared states, defaults and sizing helper for the FFT frame arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fft_pkg;

   localparam int N_PTS_DEF = 64;
   localparam int DW_DEF    = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT   = 3'd1,
      LOAD    = 3'd2,
      COMPUTE = 3'd3,
      DRAIN   = 3'd4
   } state_t;

   // ceil(log2(v)), at least 1 so counters never collapse to zero width
   function automatic int log2c(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fft_frame_arbiter_if.sv
//------------------------------------------------------------------------------
// fft_frame_arbiter_if : source, core and result signals of the frame arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fft_frame_arbiter_if #(
   parameter int DW = 32
);
   logic [1:0]    req;
   logic [1:0]    s_valid;
   logic [DW-1:0] s_data0;
   logic [DW-1:0] s_data1;
   logic [1:0]    s_ready;
   logic [1:0]    grant;
   logic          core_start;
   logic          core_valid;
   logic [DW-1:0] core_din;
   logic          core_output_start;
   logic [DW-1:0] core_dout;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_owner;
   logic          out_last;
   logic [1:0]    frame_done;
   logic          err_timeout;

   modport master (
      input  req, s_valid, s_data0, s_data1, core_output_start, core_dout,
      output s_ready, grant, core_start, core_valid, core_din,
             out_valid, out_data, out_owner, out_last, frame_done, err_timeout
   );

   modport slave (
      output req, s_valid, s_data0, s_data1, core_output_start, core_dout,
      input  s_ready, grant, core_start, core_valid, core_din,
             out_valid, out_data, out_owner, out_last, frame_done, err_timeout
   );
endinterface

`default_nettype wire

// File: rtl/fft_frame_arbiter_rr_arb2.sv
//------------------------------------------------------------------------------
// rr_arb2 : two-requester round-robin picker, source 0 favoured after reset
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
   input  logic       clk,
   input  logic       nrst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   logic r_last_grant;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = r_last_grant ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_last_grant <= 1'b1;
      end else if (en) begin
         r_last_grant <= gnt[1];
      end
   end

endmodule

`default_nettype wire

// File: rtl/fft_frame_arbiter.sv
//------------------------------------------------------------------------------
// fft_frame_arbiter : shares one FFT core between two frame sources, one frame in flight
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fft_frame_arbiter
   import fft_pkg::*;
#(
   parameter int N_PTS   = N_PTS_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = 512
) (
   input  logic               clk,
   input  logic               nrst,
   fft_frame_arbiter_if.master bus
);

   localparam int c_cnt_w = log2c(N_PTS);
   localparam int c_wd_w  = log2c(TIMEOUT);
   localparam logic [c_cnt_w-1:0] c_last_smp = c_cnt_w'(N_PTS - 1);
   localparam logic [c_wd_w-1:0]  c_last_wd  = c_wd_w'(TIMEOUT - 1);

   state_t               r_state;
   logic [1:0]           r_grant;
   logic [1:0]           r_s_ready;
   logic                 r_core_start;
   logic                 r_out_valid;
   logic [DW-1:0]        r_out_data;
   logic                 r_out_owner;
   logic                 r_out_last;
   logic [1:0]           r_frame_done;
   logic                 r_err_timeout;
   logic                 r_cos_prev;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [c_wd_w-1:0]    r_wdog;

   logic [1:0]           w_pick;
   logic                 w_arb_en;
   logic                 w_sel;
   logic                 w_load;
   logic                 w_accept;
   logic                 w_rise;
   logic [c_cnt_w-1:0]   w_cnt_nxt;

   assign w_sel     = r_grant[1];
   assign w_load    = (r_state == LOAD);
   assign w_accept  = w_load & bus.s_valid[w_sel];
   assign w_rise    = bus.core_output_start & ~r_cos_prev;
   assign w_arb_en  = (r_state == IDLE) & (|bus.req);
   assign w_cnt_nxt = r_cnt + 1'b1;

   rr_arb2 u_rr_arb2 (
      .clk  (clk),
      .nrst (nrst),
      .req  (bus.req),
      .en   (w_arb_en),
      .gnt  (w_pick)
   );

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state       <= IDLE;
         r_grant       <= 2'b00;
         r_s_ready     <= 2'b00;
         r_core_start  <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_out_owner   <= 1'b0;
         r_out_last    <= 1'b0;
         r_frame_done  <= 2'b00;
         r_err_timeout <= 1'b0;
         r_cos_prev    <= 1'b0;
         r_cnt         <= '0;
         r_wdog        <= '0;
      end else begin
         r_cos_prev   <= bus.core_output_start;
         r_core_start <= 1'b0;
         r_frame_done <= 2'b00;
         case (r_state)
            IDLE: begin
               if (|bus.req) begin
                  r_grant      <= w_pick;
                  r_core_start <= 1'b1;
                  r_state      <= GRANT;
               end
            end
            GRANT: begin
               r_s_ready <= w_sel ? 2'b10 : 2'b01;
               r_cnt     <= '0;
               r_state   <= LOAD;
            end
            LOAD: begin
               if (w_accept) begin
                  if (r_cnt == c_last_smp) begin
                     r_cnt     <= '0;
                     r_s_ready <= 2'b00;
                     r_wdog    <= '0;
                     r_state   <= COMPUTE;
                  end else begin
                     r_cnt <= w_cnt_nxt;
                  end
               end
            end
            COMPUTE: begin
               // The first result is already on core_dout in the rising-edge cycle
               if (w_rise) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= bus.core_dout;
                  r_out_owner <= w_sel;
                  r_out_last  <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= DRAIN;
               end else if (r_wdog == c_last_wd) begin
                  r_err_timeout <= 1'b1;
                  r_grant       <= 2'b00;
                  r_state       <= IDLE;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            DRAIN: begin
               if (r_out_last) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_grant     <= 2'b00;
                  r_cnt       <= '0;
                  r_state     <= IDLE;
               end else begin
                  r_out_data <= bus.core_dout;
                  r_cnt      <= w_cnt_nxt;
                  if (w_cnt_nxt == c_last_smp) begin
                     r_out_last   <= 1'b1;
                     r_frame_done <= r_grant;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.grant       = r_grant;
   assign bus.s_ready     = r_s_ready;
   assign bus.core_start  = r_core_start;
   assign bus.core_valid  = w_accept;
   assign bus.core_din    = w_load ? (w_sel ? bus.s_data1 : bus.s_data0) : '0;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_data    = r_out_data;
   assign bus.out_owner   = r_out_owner;
   assign bus.out_last    = r_out_last;
   assign bus.frame_done  = r_frame_done;
   assign bus.err_timeout = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_arbiter.sv
//------------------------------------------------------------------------------
// tb_fft_frame_arbiter : directed scoreboard bench for fft_frame_arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fft_frame_arbiter;
   import fft_pkg::*;

   localparam int NP = N_PTS_DEF;
   localparam int DW = DW_DEF;
   localparam int TO = 512;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   starts = 0;
   int   cv_count = 0;
   bit   mon_en = 1'b0;

   logic [DW-1:0] din_q[$];
   logic [DW+3:0] out_q[$];

   fft_frame_arbiter_if #(.DW(DW)) bus ();

   fft_frame_arbiter #(
      .N_PTS   (NP),
      .DW      (DW),
      .TIMEOUT (TO)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: sample at the falling edge, inputs change just after rising edges
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.core_start === 1'b1) starts++;
         if (bus.core_valid === 1'b1) begin
            cv_count++;
            if (din_q.size() > 0) chk("core_din", bus.core_din, din_q.pop_front());
            else chk("core_din_pending", din_q.size(), 1);
         end
         if (bus.out_valid === 1'b1) begin
            if (out_q.size() > 0)
               chk("out_beat", {bus.out_owner, bus.out_last, bus.frame_done, bus.out_data},
                   out_q.pop_front());
            else chk("out_pending", out_q.size(), 1);
         end else begin
            chk("idle_last_done", {bus.out_last, bus.frame_done}, 3'b000);
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_grant"}, bus.grant, 2'b00);
      chk({tag, "_s_ready"}, bus.s_ready, 2'b00);
      chk({tag, "_core_start"}, bus.core_start, 1'b0);
      chk({tag, "_core_valid"}, bus.core_valid, 1'b0);
      chk({tag, "_core_din"}, bus.core_din, '0);
      chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
      chk({tag, "_out_last"}, bus.out_last, 1'b0);
      chk({tag, "_frame_done"}, bus.frame_done, 2'b00);
      chk({tag, "_err"}, bus.err_timeout, 1'b0);
      chk({tag, "_out_data"}, bus.out_data, '0);
   endtask

   task automatic drive_sample(input logic sel, input logic [DW-1:0] d, input int i);
      bus.s_valid = 2'b11;
      if (sel) begin
         bus.s_data1 = d;
         bus.s_data0 = 32'hDEAD_0000 | i;
      end else begin
         bus.s_data0 = d;
         bus.s_data1 = 32'hDEAD_0000 | i;
      end
      din_q.push_back(d);
   endtask

   task automatic do_frame(input logic [1:0] rq, input logic [1:0] eg, input logic [15:0] base,
                           input bit gaps, input bit hang);
      logic          sel;
      logic [DW-1:0] d;
      int            cv0;
      sel = eg[1];
      bus.req = rq;
      tick();
      chk("grant", bus.grant, eg);
      chk("core_start", bus.core_start, 1'b1);
      tick();
      chk("core_start_pulse", bus.core_start, 1'b0);
      chk("s_ready_load", bus.s_ready, eg);
      cv0 = cv_count;
      for (int i = 0; i < NP; i++) begin
         if (gaps) begin
            bus.s_valid = sel ? 2'b01 : 2'b10;
            tick();
         end
         d = {16'h0000, base + 16'(i)};
         drive_sample(sel, d, i);
         tick();
         chk("s_ready", bus.s_ready, (i == NP - 1) ? 2'b00 : eg);
      end
      bus.s_valid = 2'b00;
      chk("core_valid_pulses", cv_count - cv0, NP);
      if (hang) begin
         repeat (TO - 1) tick();
         chk("err_before_limit", bus.err_timeout, 1'b0);
         tick();
         chk("err_timeout", bus.err_timeout, 1'b1);
         chk("grant_after_timeout", bus.grant, 2'b00);
         return;
      end
      repeat (4) tick();
      chk("grant_hold", bus.grant, eg);
      chk("no_out_in_compute", bus.out_valid, 1'b0);
      for (int k = 0; k < NP; k++) begin
         d = {~base, base + 16'(k)};
         bus.core_output_start = 1'b1;
         bus.core_dout = d;
         out_q.push_back({sel, (k == NP - 1), (k == NP - 1) ? eg : 2'b00, d});
         tick();
      end
      bus.core_output_start = 1'b0;
      tick();
      chk("grant_release", bus.grant, 2'b00);
      chk("out_valid_end", bus.out_valid, 1'b0);
   endtask

   initial begin
      bus.req = 2'b00;
      bus.s_valid = 2'b00;
      bus.s_data0 = '0;
      bus.s_data1 = '0;
      bus.core_output_start = 1'b0;
      bus.core_dout = '0;
      repeat (2) tick();
      mon_en = 1'b1;
      check_zero("reset");
      nrst = 1'b1;

      // Simultaneous requests alternate starting from source 0
      do_frame(2'b11, 2'b01, 16'h1000, 1'b0, 1'b0);
      do_frame(2'b11, 2'b10, 16'h2000, 1'b0, 1'b0);
      do_frame(2'b11, 2'b01, 16'h3000, 1'b0, 1'b0);

      do_frame(2'b01, 2'b01, 16'h0000, 1'b0, 1'b0);
      do_frame(2'b01, 2'b01, 16'h4000, 1'b1, 1'b0);

      do_frame(2'b01, 2'b01, 16'h5000, 1'b0, 1'b1);
      do_frame(2'b10, 2'b10, 16'h6000, 1'b0, 1'b0);
      chk("err_sticky", bus.err_timeout, 1'b1);

      // Reset in the middle of a source-1 load
      bus.req = 2'b10;
      tick();
      tick();
      for (int i = 0; i < 20; i++) begin
         drive_sample(1'b1, 32'h7000 + i, i);
         tick();
      end
      nrst = 1'b0;
      bus.s_valid = 2'b00;
      bus.req = 2'b00;
      tick();
      check_zero("midreset");
      nrst = 1'b1;
      do_frame(2'b11, 2'b01, 16'h8000, 1'b0, 1'b0);
      bus.req = 2'b00;
      repeat (3) tick();

      chk("core_start_total", starts, 9);
      chk("din_q_empty", din_q.size(), 0);
      chk("out_q_empty", out_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
